ks_adder_pipe: RTL and testbench



---
 rtl/ks_pkg.sv | 28 ++
 rtl/ks_prefix_cell.sv | 15 +
 rtl/ks_adder_pipe.sv | 150 +++++++++++++++
 tb/tb_ks_adder_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// ks_pkg: shared types and helpers for the pipelined Kogge-Stone adder.
// Stage records are sized for the widest legal operand; narrower adders zero-pad.
package ks_pkg;

  localparam int KS_MAX_W = 64;

  typedef struct packed {
    logic                vld;
    logic                c0;
    logic [KS_MAX_W-1:0] g;
    logic [KS_MAX_W-1:0] p;
    logic [KS_MAX_W-1:0] praw;
  } ks_stage_t;

  function automatic int ks_levels(input int w);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < w) n = i + 1;
    end
    return n;
  endfunction

  function automatic bit ks_width_ok(input int w);
    return (w >= 8) && (w <= KS_MAX_W) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// ks_prefix_cell: Kogge-Stone black cell merging a high and a low
// generate/propagate pair.
module ks_prefix_cell (
  input  logic i_g_hi,
  input  logic i_p_hi,
  input  logic i_g_lo,
  input  logic i_p_lo,
  output logic o_g,
  output logic o_p
);

  assign o_g = i_g_hi | (i_p_hi & i_g_lo);
  assign o_p = i_p_hi & i_p_lo;

endmodule

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready flow.
// Pre-process, every prefix level and the sum stage are registered.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = ks_levels(WIDTH);

  if (!ks_width_ok(WIDTH)) begin : g_bad_width
    $error("ks_adder_pipe: WIDTH must be a power of two in 8..64");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic             w_c0;
  ks_stage_t        w_pre;
  ks_stage_t        r_pre;
  ks_stage_t        w_stg [LEVELS+1];

  logic             r_ovld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  // One global stall: the whole pipe moves only when the output slot frees.
  assign w_adv    = ~r_ovld | out_ready;
  assign in_ready = w_adv;

  assign w_bx = sub ? ~b : b;
  assign w_c0 = sub | cin;
  assign w_p  = a ^ w_bx;
  assign w_g  = (a & w_bx)
              | {{(WIDTH-1){1'b0}}, w_p[0] & w_c0};

  always_comb begin
    w_pre      = '0;
    w_pre.vld  = in_valid;
    w_pre.c0   = w_c0;
    w_pre.g    = KS_MAX_W'(w_g);
    w_pre.p    = KS_MAX_W'(w_p);
    w_pre.praw = KS_MAX_W'(w_p);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_adv) begin
      r_pre <= w_pre;
    end
  end

  assign w_stg[0] = r_pre;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);

    logic [WIDTH-1:0] w_gi;
    logic [WIDTH-1:0] w_pi;
    logic [WIDTH-1:0] w_go;
    logic [WIDTH-1:0] w_po;
    ks_stage_t        w_nxt;
    ks_stage_t        r_q;

    assign w_gi = w_stg[k-1].g[WIDTH-1:0];
    assign w_pi = w_stg[k-1].p[WIDTH-1:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_black
        ks_prefix_cell u_cell (
          .i_g_hi (w_gi[i]),
          .i_p_hi (w_pi[i]),
          .i_g_lo (w_gi[i-D]),
          .i_p_lo (w_pi[i-D]),
          .o_g    (w_go[i]),
          .o_p    (w_po[i])
        );
      end else begin : g_pass
        assign w_go[i] = w_gi[i];
        assign w_po[i] = w_pi[i];
      end
    end

    always_comb begin
      w_nxt   = w_stg[k-1];
      w_nxt.g = KS_MAX_W'(w_go);
      w_nxt.p = KS_MAX_W'(w_po);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_adv) begin
        r_q <= w_nxt;
      end
    end

    assign w_stg[k] = r_q;
  end

  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  // Carry into bit i is the group generate of bits i-1..0 (c0 already folded).
  assign w_c    = {w_stg[LEVELS].g[WIDTH-2:0], w_stg[LEVELS].c0};
  assign w_sum  = w_stg[LEVELS].praw[WIDTH-1:0] ^ w_c;
  assign w_cout = w_stg[LEVELS].g[WIDTH-1];
  assign w_ovf  = w_c[WIDTH-1] ^ w_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovld <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_adv) begin
      r_ovld <= w_stg[LEVELS].vld;
      if (w_stg[LEVELS].vld) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign out_valid = r_ovld;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe: directed and random checks of ks_adder_pipe at WIDTH 32 and 8
// against a behavioural a +/- b model through per-DUT scoreboards.
module tb_ks_adder_pipe;

  localparam int LAT32 = 7;
  localparam int LAT8  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v32, ir32, ov32, or32, cin32, sub32, co32, ovf32;
  logic [31:0] a32, b32, s32;
  logic        v8, ir8, ov8, or8, cin8, sub8, co8, ovf8;
  logic [7:0]  a8, b8, s8;

  ks_adder_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(v32), .in_ready(ir32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(ov32), .out_ready(or32),
    .sum(s32), .cout(co32), .ovf(ovf32)
  );

  ks_adder_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8),
    .sum(s8), .cout(co8), .ovf(ovf8)
  );

  int checks = 0;
  int errors = 0;
  logic [65:0] q32[$];
  logic [65:0] q8[$];

  task automatic chk(input string tag, input logic [65:0] obs,
                     input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic logic [65:0] model(input int w, input logic [63:0] a,
                                       input logic [63:0] b,
                                       input logic cin, input logic sub);
    logic [63:0] m, bx, s;
    logic [64:0] full;
    logic co, ov;
    m    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    bx   = (sub ? ~b : b) & m;
    full = {1'b0, a & m} + {1'b0, bx} + {64'd0, (sub | cin)};
    s    = full[63:0] & m;
    co   = full[w];
    ov   = (a[w-1] == bx[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
    end else begin
      if (ov32 && or32) begin
        chk("sb32_pending", 66'(q32.size() > 0), 66'd1);
        if (q32.size() > 0)
          chk("sb32", {ovf32, co32, 32'd0, s32}, q32.pop_front());
      end
      if (v32 && ir32)
        q32.push_back(model(32, {32'd0, a32}, {32'd0, b32}, cin32, sub32));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
    end else begin
      if (ov8 && or8) begin
        chk("sb8_pending", 66'(q8.size() > 0), 66'd1);
        if (q8.size() > 0)
          chk("sb8", {ovf8, co8, 56'd0, s8}, q8.pop_front());
      end
      if (v8 && ir8)
        q8.push_back(model(8, {56'd0, a8}, {56'd0, b8}, cin8, sub8));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accept edge (as 1) until out_valid shows.
  task automatic wait_out32(output int n);
    n = 1;
    @(negedge clk);
    while (!ov32 && n < 40) begin
      tick;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_out8(output int n);
    n = 1;
    @(negedge clk);
    while (!ov8 && n < 40) begin
      tick;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic dir32(input string t, input logic [31:0] a,
                       input logic [31:0] b, input logic ci, input logic sb,
                       input logic [31:0] es, input logic eco,
                       input logic eov);
    int n;
    a32 = a; b32 = b; cin32 = ci; sub32 = sb; v32 = 1'b1;
    tick;
    v32 = 1'b0;
    wait_out32(n);
    chk({t, "_lat"}, 66'(n), 66'(LAT32));
    chk({t, "_sum"}, 66'(s32), 66'(es));
    chk({t, "_cout"}, 66'(co32), 66'(eco));
    chk({t, "_ovf"}, 66'(ovf32), 66'(eov));
    tick;
  endtask

  task automatic dir8(input string t, input logic [7:0] a,
                      input logic [7:0] b, input logic ci, input logic sb,
                      input logic [7:0] es, input logic eco,
                      input logic eov);
    int n;
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; v8 = 1'b1;
    tick;
    v8 = 1'b0;
    wait_out8(n);
    chk({t, "_lat"}, 66'(n), 66'(LAT8));
    chk({t, "_sum"}, 66'(s8), 66'(es));
    chk({t, "_cout"}, 66'(co8), 66'(eco));
    chk({t, "_ovf"}, 66'(ovf8), 66'(eov));
    tick;
  endtask

  initial begin
    logic [65:0] held;
    int i;
    int n;
    int nacc;
    rst = 1'b1;
    v32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; or32 = 1;
    v8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 1;
    held = '0;
    tick;
    tick;
    @(negedge clk);
    chk("rst_ovld32", 66'(ov32), 66'd0);
    chk("rst_sum32", 66'(s32), 66'd0);
    chk("rst_cout32", 66'(co32), 66'd0);
    chk("rst_ovf32", 66'(ovf32), 66'd0);
    chk("rst_ovld8", 66'(ov8), 66'd0);
    chk("rst_sum8", 66'(s8), 66'd0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready32", 66'(ir32), 66'd1);
    chk("post_rst_ready8", 66'(ir8), 66'd1);
    tick;

    dir32("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    dir32("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    dir32("sub", 32'd5, 32'd7, 1'b1, 1'b0 | 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    dir32("subovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    dir32("cin", 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0101, 1'b0, 1'b0);

    // Ten back-to-back beats with the consumer stalled for four cycles.
    i = 0;
    for (int j = 0; j < 40; j++) begin
      or32 = !(j >= 8 && j <= 11);
      v32 = (i < 10);
      a32 = 32'(i); b32 = 32'(i); cin32 = i[0]; sub32 = 1'b0;
      @(negedge clk);
      if (j >= 8 && j <= 11) chk("stall_ready", 66'(ir32), 66'd0);
      if (j == 8) held = {ovf32, co32, s32, 31'd0, ov32};
      if (j >= 9 && j <= 11)
        chk("stall_hold", {ovf32, co32, s32, 31'd0, ov32}, held);
      if (j == 8) chk("stall_ovld", 66'(ov32), 66'd1);
      if (v32 && ir32) i++;
      tick;
    end
    chk("stream_accepted", 66'(i), 66'd10);
    chk("stream_drain", 66'(q32.size()), 66'd0);

    // Three beats in flight, then a one-cycle reset discards them.
    for (int j = 0; j < 16; j++) begin
      v32 = (j < 3);
      a32 = 32'(100 + j); b32 = 32'(j); cin32 = 1'b0; sub32 = 1'b0;
      rst = (j == 4);
      @(negedge clk);
      if (j >= 5) chk("rst_quiet", 66'(ov32), 66'd0);
      if (j == 5) chk("rst_sum", 66'(s32), 66'd0);
      tick;
    end
    dir32("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
          32'h2345_678A, 1'b0, 1'b0);

    dir8("w8_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    dir8("w8_sovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    dir8("w8_sub", 8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);

    nacc = 0;
    for (int c = 0; c < 40000 && nacc < 10000; c++) begin
      v8   = ($urandom_range(3) != 0);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      sub8 = 1'($urandom);
      or8  = ($urandom_range(3) != 0);
      @(negedge clk);
      if (v8 && ir8) nacc++;
      tick;
    end
    chk("rand_accepted", 66'(nacc), 66'd10000);
    v8 = 1'b0;
    or8 = 1'b1;
    repeat (12) tick;
    @(negedge clk);
    chk("rand_drain", 66'(q8.size()), 66'd0);
    chk("final_drain32", 66'(q32.size()), 66'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
